// File: rtl/icache_status_array_pkg.sv
// icache_status_array shared types and defaults.
// Sweep FSM encoding and default geometry for the status store.
package icache_status_array_pkg;

  localparam int NUM_SETS_D    = 16;
  localparam int NUM_WAYS_D    = 4;
  localparam int STATUS_BITS_D = 2;
  localparam int TAG_WIDTH_D   = 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/icache_status_array_if.sv
// Command/response bundle of the icache status array.
// master: valid,wen,addr,wmask,wdata,tag,flush -> ; <- ready,rvalid,rdata,rtag,busy
interface icache_status_array_if #(
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int STATUS_BITS = 2,
  parameter int TAG_WIDTH   = 1
);
  localparam int AW = $clog2(NUM_SETS);
  localparam int RW = NUM_WAYS * STATUS_BITS;

  logic                 valid;
  logic                 wen;
  logic [AW-1:0]        addr;
  logic [NUM_WAYS-1:0]  wmask;
  logic [RW-1:0]        wdata;
  logic [TAG_WIDTH-1:0] tag;
  logic                 flush;
  logic                 ready;
  logic                 rvalid;
  logic [RW-1:0]        rdata;
  logic [TAG_WIDTH-1:0] rtag;
  logic                 busy;

  modport master (
    output valid, wen, addr, wmask, wdata, tag, flush,
    input  ready, rvalid, rdata, rtag, busy
  );

  modport slave (
    input  valid, wen, addr, wmask, wdata, tag, flush,
    output ready, rvalid, rdata, rtag, busy
  );

endinterface

// File: rtl/icache_status_array_regfile.sv
// Per-set status registers: masked write port, clear port, sync read.
// Ports: i_clr_* sweep clear, i_wr_* masked write, i_rd_* read -> o_rdata (0 if no read).
module icache_status_array_regfile #(
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int STATUS_BITS = 2,
  localparam int AW = $clog2(NUM_SETS),
  localparam int RW = NUM_WAYS * STATUS_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_hold,
  input  logic                i_clr_en,
  input  logic [AW-1:0]       i_clr_addr,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [NUM_WAYS-1:0] i_wmask,
  input  logic [RW-1:0]       i_wdata,
  input  logic                i_rd_en,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [RW-1:0]       o_rdata
);

  logic [RW-1:0] r_mem [NUM_SETS];
  logic [RW-1:0] r_rdata;
  logic [RW-1:0] w_bitmask;

  always_comb begin
    w_bitmask = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_bitmask[w*STATUS_BITS +: STATUS_BITS] =
        {STATUS_BITS{i_wmask[w]}};
    end
  end

  // Storage needs no reset: the sweep clears every set after reset.
  always_ff @(posedge clk) begin
    if (i_clr_en) begin
      r_mem[i_clr_addr] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= (r_mem[i_wr_addr] & ~w_bitmask)
                        | (i_wdata & w_bitmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (!i_hold) begin
      r_rdata <= i_rd_en ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_status_array.sv
// Instruction-cache status array: sweep FSM, accept logic, read pipeline.
// Ports: clk, rst (sync high), i_halt freeze, bus (slave) command/response.
module icache_status_array
  import icache_status_array_pkg::*;
#(
  parameter int NUM_SETS    = NUM_SETS_D,
  parameter int NUM_WAYS    = NUM_WAYS_D,
  parameter int STATUS_BITS = STATUS_BITS_D,
  parameter int TAG_WIDTH   = TAG_WIDTH_D
) (
  input  logic clk,
  input  logic rst,
  input  logic i_halt,
  icache_status_array_if.slave bus
);

  localparam int AW = $clog2(NUM_SETS);
  localparam int RW = NUM_WAYS * STATUS_BITS;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [AW-1:0]        r_ptr;
  logic                 r_valid;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [RW-1:0]        w_rdata;

  logic w_sweep;
  logic w_last;
  logic w_ready;
  logic w_acc;
  logic w_wr;
  logic w_rd;

  assign w_sweep = (r_state != ST_IDLE);
  assign w_last  = (r_ptr == AW'(NUM_SETS - 1));
  assign w_ready = ~i_halt & (r_state == ST_IDLE);
  assign w_acc   = bus.valid & w_ready;
  assign w_wr    = w_acc & bus.wen;
  assign w_rd    = w_acc & ~bus.wen;

  always_comb begin
    w_state_nxt = r_state;
    if (!i_halt) begin
      case (r_state)
        ST_INIT:  if (w_last)    w_state_nxt = ST_IDLE;
        ST_IDLE:  if (bus.flush) w_state_nxt = ST_FLUSH;
        ST_FLUSH: if (w_last)    w_state_nxt = ST_IDLE;
        default:                 w_state_nxt = ST_INIT;
      endcase
    end
  end

  // The pointer wraps to 0 on the last set, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (!i_halt) begin
      r_state <= w_state_nxt;
      if (w_sweep) r_ptr <= r_ptr + AW'(1);
      r_valid <= w_rd;
      r_tag   <= w_acc ? bus.tag : '0;
    end
  end

  icache_status_array_regfile #(
    .NUM_SETS    (NUM_SETS),
    .NUM_WAYS    (NUM_WAYS),
    .STATUS_BITS (STATUS_BITS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (i_halt),
    .i_clr_en   (w_sweep & ~i_halt),
    .i_clr_addr (r_ptr),
    .i_wr_en    (w_wr),
    .i_wr_addr  (bus.addr),
    .i_wmask    (bus.wmask),
    .i_wdata    (bus.wdata),
    .i_rd_en    (w_rd),
    .i_rd_addr  (bus.addr),
    .o_rdata    (w_rdata)
  );

  assign bus.ready  = w_ready;
  assign bus.rvalid = r_valid;
  assign bus.rdata  = w_rdata;
  assign bus.rtag   = r_tag;
  assign bus.busy   = w_sweep;

endmodule
